// File: rtl/fp_operand_unpacker.sv
// Unpacks one IEEE-754 SP/DP word into sign, biased exponent and hidden-bit mantissa with a class code.
// Denormals are normalised one bit per cycle. ldin pulses once when the registered outputs are valid.
module fp_operand_unpacker #(
  parameter int MANT_W  = 53,
  parameter int EXP_W   = 11,
  parameter int SHIFT_W = 6
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               start,
  input  logic [63:0]        word,
  input  logic               mode,
  output logic               busy,
  output logic               ldin,
  output logic [MANT_W-1:0]  mant,
  output logic [EXP_W-1:0]   exp,
  output logic               sign,
  output logic [2:0]         flags,
  output logic [SHIFT_W-1:0] norm_shift
);

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_CLASSIFY = 2'd1,
    S_NORM     = 2'd2,
    S_DONE     = 2'd3
  } state_t;

  localparam logic [2:0] FL_DENORM = 3'b000;
  localparam logic [2:0] FL_ZERO   = 3'b001;
  localparam logic [2:0] FL_INF    = 3'b010;
  localparam logic [2:0] FL_NAN    = 3'b011;
  localparam logic [2:0] FL_NORMAL = 3'b100;

  localparam logic [MANT_W-1:0]  HID_DP    = {1'b1, {(MANT_W-1){1'b0}}};
  localparam logic [MANT_W-1:0]  HID_SP    = {{(MANT_W-24){1'b0}}, 1'b1, 23'd0};
  localparam logic [MANT_W-1:0]  MANT_ZERO = {MANT_W{1'b0}};
  localparam logic [EXP_W-1:0]   EXP_ZERO  = {EXP_W{1'b0}};
  localparam logic [EXP_W-1:0]   EXP_ONE   = {{(EXP_W-1){1'b0}}, 1'b1};
  localparam logic [SHIFT_W-1:0] SH_ZERO   = {SHIFT_W{1'b0}};
  localparam logic [SHIFT_W-1:0] SH_ONE    = {{(SHIFT_W-1){1'b0}}, 1'b1};

  state_t              state_q, state_d;
  logic [63:0]         word_q, word_d;
  logic                mode_q, mode_d;
  logic [MANT_W-1:0]   work_q, work_d;
  logic [SHIFT_W-1:0]  cnt_q, cnt_d;
  logic                busy_q, busy_d;
  logic                ldin_q, ldin_d;
  logic [MANT_W-1:0]   mant_q, mant_d;
  logic [EXP_W-1:0]    exp_q, exp_d;
  logic                sign_q, sign_d;
  logic [2:0]          flags_q, flags_d;
  logic [SHIFT_W-1:0]  norm_shift_q, norm_shift_d;

  logic                sgn_s;
  logic [EXP_W-1:0]    e_s;
  logic [MANT_W-1:0]   f_s;
  logic [MANT_W-1:0]   hidden_s;
  logic                e_ones_s;
  logic                e_zero_s;
  logic                f_zero_s;
  logic [MANT_W-1:0]   shifted_s;
  logic                norm_hit_s;
  logic                accept_s;

  // State and output registers
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q      <= S_IDLE;
      word_q       <= 64'd0;
      mode_q       <= 1'b0;
      work_q       <= MANT_ZERO;
      cnt_q        <= SH_ZERO;
      busy_q       <= 1'b0;
      ldin_q       <= 1'b0;
      mant_q       <= MANT_ZERO;
      exp_q        <= EXP_ZERO;
      sign_q       <= 1'b0;
      flags_q      <= 3'b000;
      norm_shift_q <= SH_ZERO;
    end else begin
      state_q      <= state_d;
      word_q       <= word_d;
      mode_q       <= mode_d;
      work_q       <= work_d;
      cnt_q        <= cnt_d;
      busy_q       <= busy_d;
      ldin_q       <= ldin_d;
      mant_q       <= mant_d;
      exp_q        <= exp_d;
      sign_q       <= sign_d;
      flags_q      <= flags_d;
      norm_shift_q <= norm_shift_d;
    end
  end

  // Field extraction from the latched operand; SP fields are zero-extended into the DP-sized lanes
  always_comb begin
    if (mode_q) begin
      sgn_s    = word_q[63];
      e_s      = EXP_W'(word_q[62:52]);
      f_s      = MANT_W'(word_q[51:0]);
      hidden_s = HID_DP;
      e_ones_s = &word_q[62:52];
      e_zero_s = ~|word_q[62:52];
      f_zero_s = ~|word_q[51:0];
    end else begin
      sgn_s    = word_q[31];
      e_s      = EXP_W'(word_q[30:23]);
      f_s      = MANT_W'(word_q[22:0]);
      hidden_s = HID_SP;
      e_ones_s = &word_q[30:23];
      e_zero_s = ~|word_q[30:23];
      f_zero_s = ~|word_q[22:0];
    end
  end

  // A denormal always needs at least one shift, so NORM finishes on the shift that lands bit H
  assign shifted_s  = {work_q[MANT_W-2:0], 1'b0};
  assign norm_hit_s = |(shifted_s & hidden_s);
  assign accept_s   = start && ((state_q == S_IDLE) || (state_q == S_DONE));

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (start) state_d = S_CLASSIFY;
        else       state_d = S_IDLE;
      end
      S_CLASSIFY: begin
        if (e_zero_s && !f_zero_s) state_d = S_NORM;
        else                       state_d = S_DONE;
      end
      S_NORM: begin
        if (norm_hit_s) state_d = S_DONE;
        else            state_d = S_NORM;
      end
      S_DONE: begin
        if (start) state_d = S_CLASSIFY;
        else       state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Datapath and output next values; visible outputs only change on entry to DONE
  always_comb begin
    word_d       = word_q;
    mode_d       = mode_q;
    work_d       = work_q;
    cnt_d        = cnt_q;
    mant_d       = mant_q;
    exp_d        = exp_q;
    sign_d       = sign_q;
    flags_d      = flags_q;
    norm_shift_d = norm_shift_q;
    ldin_d       = (state_d == S_DONE);
    busy_d       = (state_d == S_CLASSIFY) || (state_d == S_NORM);

    if (accept_s) begin
      word_d = word;
      mode_d = mode;
    end else begin
      word_d = word_q;
      mode_d = mode_q;
    end

    case (state_q)
      S_CLASSIFY: begin
        if (e_zero_s && !f_zero_s) begin
          work_d = f_s;
          cnt_d  = SH_ZERO;
        end else begin
          sign_d       = sgn_s;
          norm_shift_d = SH_ZERO;
          if (e_ones_s) begin
            exp_d = e_s;
            if (!f_zero_s) begin
              flags_d = FL_NAN;
              mant_d  = f_s | hidden_s;
            end else begin
              flags_d = FL_INF;
              mant_d  = MANT_ZERO;
            end
          end else if (e_zero_s) begin
            flags_d = FL_ZERO;
            mant_d  = MANT_ZERO;
            exp_d   = EXP_ZERO;
          end else begin
            flags_d = FL_NORMAL;
            mant_d  = f_s | hidden_s;
            exp_d   = e_s;
          end
        end
      end
      S_NORM: begin
        work_d = shifted_s;
        cnt_d  = cnt_q + SH_ONE;
        if (norm_hit_s) begin
          mant_d       = shifted_s;
          exp_d        = EXP_ONE;
          sign_d       = sgn_s;
          flags_d      = FL_DENORM;
          norm_shift_d = cnt_q + SH_ONE;
        end else begin
          mant_d = mant_q;
        end
      end
      default: begin
        work_d = work_q;
      end
    endcase
  end

  assign busy       = busy_q;
  assign ldin       = ldin_q;
  assign mant       = mant_q;
  assign exp        = exp_q;
  assign sign       = sign_q;
  assign flags      = flags_q;
  assign norm_shift = norm_shift_q;

endmodule
